axi4l_wb_bridge_mux: RTL and testbench
======================================

Name: axi4l_wb_bridge_mux

Overview:
Parametrised AXI4-Lite slave to N-channel Wishbone master bridge with address decode, so several Wishbone DSP cores (IDFT, DFT, FIR, IIR, ...) share one AXI4-Lite port. Serialises one transaction at a time and arbitrates fairly between reads and writes. Adds decode-miss (DECERR), Wishbone error and bus-timeout (SLVERR) responses. Sits between the system AXI4-Lite crossbar and the Wishbone core tops.

Parameters:
ADDR_WIDTH, 32, AXI/Wishbone address width
DATA_WIDTH, 32, data width; must be 32 or 64; STRB_WIDTH = DATA_WIDTH/8
NUM_SLAVES, 4, number of Wishbone channels (1..16)
TIMEOUT_CYCLES, 256, Wishbone cycles before abort; 0 disables timeout
SLV_BASE, {32'h7000_3000, 32'h7000_2000, 32'h7000_1000, 32'h7000_0000}, packed per-channel base address, channel 0 in LSBs
SLV_MASK, {4{32'hFFFF_F000}}, packed per-channel decode mask

Ports:
clk_i  in  1  clock; Wishbone side runs on the same clock
rst_ni  in  1  asynchronous active-low reset
s_aw_addr/s_aw_valid/s_aw_ready  in/in/out  ADDR_WIDTH/1/1  AXI write address
s_w_data/s_w_strb/s_w_valid/s_w_ready  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  AXI write data
s_b_resp/s_b_valid/s_b_ready  out/out/in  2/1/1  AXI write response
s_ar_addr/s_ar_valid/s_ar_ready  in/in/out  ADDR_WIDTH/1/1  AXI read address
s_r_data/s_r_resp/s_r_valid/s_r_ready  out/out/out/in  DATA_WIDTH/2/1/1  AXI read data
wb_adr_o  out  ADDR_WIDTH  shared address
wb_dat_o  out  DATA_WIDTH  shared write data
wb_sel_o  out  STRB_WIDTH  shared byte select
wb_we_o  out  1  shared write enable
wb_cyc_o  out  NUM_SLAVES  per-channel cycle
wb_stb_o  out  NUM_SLAVES  per-channel strobe
wb_dat_i  in  NUM_SLAVES*DATA_WIDTH  packed read data, channel 0 in LSBs
wb_ack_i  in  NUM_SLAVES  per-channel ack
wb_err_i  in  NUM_SLAVES  per-channel error

Behaviour:
- Reset (async assert, sync deassert): all outputs 0; FSM in IDLE; timeout counter 0; write-priority flag = write.
- FSM states: IDLE, WB_CYC, RESP.
- IDLE: write is pending when s_aw_valid and s_w_valid are both high; read is pending when s_ar_valid is high.
  - Only one pending: serve it.
  - Both pending: serve the side indicated by the priority flag, then toggle the flag (strict alternation).
  - Accept write: pulse s_aw_ready and s_w_ready together for exactly one cycle; capture addr, data, strb.
  - Accept read: pulse s_ar_ready for one cycle; capture addr.
  - AW without W (or W without AW): no ready asserted.
- Decode in the accept cycle: hit[i] = (addr & SLV_MASK[i]) == SLV_BASE[i]; lowest index wins.
  - No hit: go to RESP with resp=2'b11 and r_data=0; no Wishbone cycle is issued.
  - Hit: go to WB_CYC.
- WB_CYC: cyc/stb of the selected channel only are high.
  - wb_adr_o = captured addr; wb_we_o = write; wb_sel_o = strb for writes, all ones for reads.
  - wb_dat_o = captured data for writes, 0 for reads.
  - Stay until the selected wb_ack_i or wb_err_i is high. Unselected channels' ack/err are ignored.
  - On ack: resp=2'b00; r_data = selected wb_dat_i slice.
  - On err: resp=2'b10; r_data=0. Ack and err in the same cycle: err wins.
  - Timeout counter increments each WB_CYC cycle. At count == TIMEOUT_CYCLES-1 with no ack/err: drop cyc/stb, resp=2'b10, r_data=0.
  - In every exit case: cyc/stb are deasserted and the FSM moves to RESP on the next edge.
- RESP: s_b_valid (write) or s_r_valid (read) is held with stable resp/data until the matching ready is high.
  - Then return to IDLE; clear timeout counter.
  - A new request cannot be accepted in the same cycle as the response handshake.
- Latency with a zero-wait slave (ack combinational from stb): accept at T, cyc/stb at T+1, valid at T+2. Decode miss: valid at T+1.
- Only one transaction is outstanding; no pipelined Wishbone.
- Reset mid-transaction aborts immediately. cyc/stb drop asynchronously and no response is issued.

Decomposition:
- Package axi4l_wb_pkg: AXI resp constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11), FSM state enum, default base/mask constants.
- One sub-module axi4l_wb_decode: combinational base/mask decoder returning a one-hot hit vector and a miss flag.
- FSM, arbitration and timeout counter stay in the top module.

Test Plan:
- Write 0x7000_1004 data 0xDEADBEEF strb 0xF, channel 1 acks after 3 cycles -> only cyc[1]/stb[1] high, wb_sel_o=0xF, b_resp=00.
- Read 0x7000_2008, channel 2 acks immediately with 0x12345678 -> r_data=0x12345678, r_resp=00, r_valid at T+2.
- Read 0x8000_0000 -> no cyc asserted, r_resp=11, r_data=0 at T+1.
- Write to channel 3 with no ack and TIMEOUT_CYCLES=256 -> cyc[3] drops after 256 cycles, b_resp=10.
- AW+W and AR asserted together, both held for 4 transactions -> order W,R,W,R after reset; channel raising ack and err together -> resp=10.
- Reset asserted during WB_CYC, and r_ready held low 10 cycles -> reset: cyc/stb/valid drop immediately; hold: r_valid/r_data stable until accepted.

Source files
------------

// File: rtl/axi4l_wb_pkg.sv
// Shared constants for the AXI4-Lite to multi-channel Wishbone bridge.
// Holds the AXI response codes, the bridge FSM states and the default channel decode map.
package axi4l_wb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB_CYC = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Four 4 KiB windows starting at 0x7000_0000, channel 0 in the LSBs.
  localparam logic [127:0] DEF_SLV_BASE = {32'h7000_3000, 32'h7000_2000,
                                           32'h7000_1000, 32'h7000_0000};
  localparam logic [127:0] DEF_SLV_MASK = {4{32'hFFFF_F000}};

endpackage

// File: rtl/axi4l_wb_decode.sv
// Combinational base/mask address decoder.
// Returns a one-hot hit vector in which the lowest matching channel wins, plus a miss flag.
module axi4l_wb_decode #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [NUM_SLAVES-1:0] o_hit,
  output logic                  o_miss
);

  always_comb begin
    o_hit  = '0;
    o_miss = 1'b1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (o_miss && ((i_addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                     SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        o_hit[i] = 1'b1;
        o_miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi4l_wb_bridge_mux.sv
// AXI4-Lite slave that serialises requests onto N Wishbone channels selected by address decode.
// Reads and writes alternate when both are pending; it generates DECERR on a miss and SLVERR on a Wishbone error or timeout.
module axi4l_wb_bridge_mux
  import axi4l_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = DEF_SLV_MASK,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [ADDR_WIDTH-1:0]            s_aw_addr,
  input  logic                             s_aw_valid,
  output logic                             s_aw_ready,
  input  logic [DATA_WIDTH-1:0]            s_w_data,
  input  logic [STRB_WIDTH-1:0]            s_w_strb,
  input  logic                             s_w_valid,
  output logic                             s_w_ready,
  output logic [1:0]                       s_b_resp,
  output logic                             s_b_valid,
  input  logic                             s_b_ready,
  input  logic [ADDR_WIDTH-1:0]            s_ar_addr,
  input  logic                             s_ar_valid,
  output logic                             s_ar_ready,
  output logic [DATA_WIDTH-1:0]            s_r_data,
  output logic [1:0]                       s_r_resp,
  output logic                             s_r_valid,
  input  logic                             s_r_ready,
  output logic [ADDR_WIDTH-1:0]            wb_adr_o,
  output logic [DATA_WIDTH-1:0]            wb_dat_o,
  output logic [STRB_WIDTH-1:0]            wb_sel_o,
  output logic                             wb_we_o,
  output logic [NUM_SLAVES-1:0]            wb_cyc_o,
  output logic [NUM_SLAVES-1:0]            wb_stb_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wb_dat_i,
  input  logic [NUM_SLAVES-1:0]            wb_ack_i,
  input  logic [NUM_SLAVES-1:0]            wb_err_i
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e                  r_state;
  logic                    r_prio_wr;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_adr;
  logic [DATA_WIDTH-1:0]   r_wdat;
  logic [STRB_WIDTH-1:0]   r_sel;
  logic [NUM_SLAVES-1:0]   r_cyc;
  logic [TW-1:0]           r_tcnt;
  logic [1:0]              r_resp;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_bvalid;
  logic                    r_rvalid;

  logic                    w_idle;
  logic                    w_wr_pend;
  logic                    w_rd_pend;
  logic                    w_take_wr;
  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_dec_addr;
  logic [NUM_SLAVES-1:0]   w_hit;
  logic                    w_miss;
  logic                    w_ack;
  logic                    w_err;
  logic                    w_tmo;
  logic                    w_resp_done;
  logic [DATA_WIDTH-1:0]   w_rdata;

  // Handshakes use AXI valid/ready: a beat transfers on a rising edge where both are high.
  // The ready signals are decoded from the incoming valids only while IDLE, so each accept is a single-cycle pulse.
  assign w_idle     = rst_ni & (r_state == ST_IDLE);
  assign w_wr_pend  = s_aw_valid & s_w_valid;
  assign w_rd_pend  = s_ar_valid;
  assign w_take_wr  = w_wr_pend & (~w_rd_pend | r_prio_wr);
  assign w_accept   = w_idle & (w_wr_pend | w_rd_pend);
  assign s_aw_ready = w_idle & w_take_wr;
  assign s_w_ready  = w_idle & w_take_wr;
  assign s_ar_ready = w_idle & w_rd_pend & ~w_take_wr;
  assign w_dec_addr = w_take_wr ? s_aw_addr : s_ar_addr;

  axi4l_wb_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_decode (
    .i_addr (w_dec_addr),
    .o_hit  (w_hit),
    .o_miss (w_miss)
  );

  // Only the channel that owns the cycle is listened to.
  assign w_ack       = |(r_cyc & wb_ack_i);
  assign w_err       = |(r_cyc & wb_err_i);
  assign w_tmo       = (TIMEOUT_CYCLES != 0) && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_resp_done = (r_bvalid & s_b_ready) | (r_rvalid & s_r_ready);

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_cyc[i]) w_rdata = w_rdata | wb_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_prio_wr <= 1'b1;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_sel     <= '0;
      r_cyc     <= '0;
      r_tcnt    <= '0;
      r_resp    <= RESP_OKAY;
      r_rdata   <= '0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we   <= w_take_wr;
            r_adr  <= w_dec_addr;
            r_wdat <= w_take_wr ? s_w_data : '0;
            r_sel  <= w_take_wr ? s_w_strb : '1;
            r_tcnt <= '0;
            if (w_wr_pend && w_rd_pend) r_prio_wr <= ~r_prio_wr;
            if (w_miss) begin
              r_resp   <= RESP_DECERR;
              r_rdata  <= '0;
              r_bvalid <= w_take_wr;
              r_rvalid <= ~w_take_wr;
              r_state  <= ST_RESP;
            end else begin
              r_cyc   <= w_hit;
              r_state <= ST_WB_CYC;
            end
          end
        end
        ST_WB_CYC: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (w_ack || w_err || w_tmo) begin
            // An error beats a simultaneous ack; a timeout is reported like an error.
            if (w_ack && !w_err) begin
              r_resp  <= RESP_OKAY;
              r_rdata <= w_rdata;
            end else begin
              r_resp  <= RESP_SLVERR;
              r_rdata <= '0;
            end
            r_cyc    <= '0;
            r_bvalid <= r_we;
            r_rvalid <= ~r_we;
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_resp_done) begin
            r_bvalid <= 1'b0;
            r_rvalid <= 1'b0;
            r_tcnt   <= '0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wb_adr_o  = r_adr;
  assign wb_dat_o  = r_wdat;
  assign wb_sel_o  = r_sel;
  assign wb_we_o   = r_we;
  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_cyc;
  assign s_b_resp  = r_resp;
  assign s_b_valid = r_bvalid;
  assign s_r_resp  = r_resp;
  assign s_r_data  = r_rdata;
  assign s_r_valid = r_rvalid;

endmodule

// File: tb/tb_axi4l_wb_bridge_mux.sv
// Bench for axi4l_wb_bridge_mux: directed AXI transactions against configurable Wishbone responders.
// A transaction-level model checks every cycle, and per-transaction literal expectations are checked alongside it.
module tb_axi4l_wb_bridge_mux;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int SW  = DW / 8;
  localparam int TMO = 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    s_aw_addr = '0;
  logic             s_aw_valid = 1'b0;
  logic             s_aw_ready;
  logic [DW-1:0]    s_w_data = '0;
  logic [SW-1:0]    s_w_strb = '0;
  logic             s_w_valid = 1'b0;
  logic             s_w_ready;
  logic [1:0]       s_b_resp;
  logic             s_b_valid;
  logic             s_b_ready = 1'b1;
  logic [AW-1:0]    s_ar_addr = '0;
  logic             s_ar_valid = 1'b0;
  logic             s_ar_ready;
  logic [DW-1:0]    s_r_data;
  logic [1:0]       s_r_resp;
  logic             s_r_valid;
  logic             s_r_ready = 1'b1;
  logic [AW-1:0]    wb_adr_o;
  logic [DW-1:0]    wb_dat_o;
  logic [SW-1:0]    wb_sel_o;
  logic             wb_we_o;
  logic [NS-1:0]    wb_cyc_o;
  logic [NS-1:0]    wb_stb_o;
  logic [NS*DW-1:0] wb_dat_i;
  logic [NS-1:0]    wb_ack_i;
  logic [NS-1:0]    wb_err_i;

  axi4l_wb_bridge_mux #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_SLAVES     (NS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .s_aw_addr  (s_aw_addr),
    .s_aw_valid (s_aw_valid),
    .s_aw_ready (s_aw_ready),
    .s_w_data   (s_w_data),
    .s_w_strb   (s_w_strb),
    .s_w_valid  (s_w_valid),
    .s_w_ready  (s_w_ready),
    .s_b_resp   (s_b_resp),
    .s_b_valid  (s_b_valid),
    .s_b_ready  (s_b_ready),
    .s_ar_addr  (s_ar_addr),
    .s_ar_valid (s_ar_valid),
    .s_ar_ready (s_ar_ready),
    .s_r_data   (s_r_data),
    .s_r_resp   (s_r_resp),
    .s_r_valid  (s_r_valid),
    .s_r_ready  (s_r_ready),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i)
  );

  // Wishbone responders: mode 0 ack, 1 err, 2 ack+err, 3 silent; reply after cfg_lat strobe cycles
  int          cfg_lat  [NS];
  int          cfg_mode [NS];
  logic [DW-1:0] cfg_dat [NS];
  logic        noise = 1'b0;
  int          s_cnt [NS];

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) s_cnt[i] <= wb_stb_o[i] ? s_cnt[i] + 1 : 0;
  end

  always_comb begin
    wb_ack_i = '0;
    wb_err_i = '0;
    wb_dat_i = '0;
    for (int i = 0; i < NS; i++) begin
      wb_ack_i[i] = (wb_stb_o[i] && s_cnt[i] == cfg_lat[i] && (cfg_mode[i] == 0 || cfg_mode[i] == 2))
                    || (noise && !wb_stb_o[i]);
      wb_err_i[i] = (wb_stb_o[i] && s_cnt[i] == cfg_lat[i] && (cfg_mode[i] == 1 || cfg_mode[i] == 2))
                    || (noise && !wb_stb_o[i]);
      wb_dat_i[i*DW +: DW] = cfg_dat[i];
    end
  end

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Each channel owns the 4 KiB page at 0x7000_0000 + ch*0x1000
  function automatic int model_decode(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++) begin
      if (a[31:12] == 20'h70000 + 20'(i)) return i;
    end
    return -1;
  endfunction

  // transaction-level model: one outstanding transaction, with phase counted from the accept cycle
  logic          m_busy = 1'b0;
  logic          m_prio_w = 1'b1;
  logic          m_we;
  int            m_ch, m_phase, m_d;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdat, m_rdat;
  logic [SW-1:0] m_strb;
  logic [1:0]    m_resp;

  always @(negedge clk) begin
    logic exp_awr, exp_arr, exp_bv, exp_rv, wp, rp, take_w;
    logic [NS-1:0] exp_cyc;
    exp_awr = 1'b0; exp_arr = 1'b0; exp_bv = 1'b0; exp_rv = 1'b0; exp_cyc = '0;
    if (!rst_n) begin
      m_busy   = 1'b0;
      m_prio_w = 1'b1;
      chk("rst_cyc", wb_cyc_o, 0);
      chk("rst_stb", wb_stb_o, 0);
      chk("rst_bvalid", s_b_valid, 0);
      chk("rst_rvalid", s_r_valid, 0);
    end else begin
      if (!m_busy) begin
        wp = s_aw_valid && s_w_valid;
        rp = s_ar_valid;
        if (wp || rp) begin
          take_w = wp && (!rp || m_prio_w);
          if (wp && rp) m_prio_w = !m_prio_w;
          m_we   = take_w;
          m_addr = take_w ? s_aw_addr : s_ar_addr;
          m_wdat = take_w ? s_w_data : '0;
          m_strb = take_w ? s_w_strb : '1;
          m_ch   = model_decode(m_addr);
          if (m_ch < 0) begin
            m_d = 0; m_resp = 2'b11; m_rdat = '0;
          end else if (cfg_mode[m_ch] == 3) begin
            m_d = TMO; m_resp = 2'b10; m_rdat = '0;
          end else begin
            m_d    = (cfg_lat[m_ch] + 1 < TMO) ? cfg_lat[m_ch] + 1 : TMO;
            m_resp = (cfg_mode[m_ch] == 0 && cfg_lat[m_ch] + 1 <= TMO) ? 2'b00 : 2'b10;
            m_rdat = (m_resp == 2'b00) ? cfg_dat[m_ch] : '0;
          end
          m_phase = 0;
          m_busy  = 1'b1;
          exp_awr = take_w;
          exp_arr = !take_w;
        end
      end else begin
        m_phase++;
        if (m_ch >= 0 && m_phase <= m_d) exp_cyc[m_ch] = 1'b1;
        else if (m_phase > m_d) begin
          exp_bv = m_we;
          exp_rv = !m_we;
        end
      end
      chk("aw_ready", s_aw_ready, exp_awr);
      chk("w_ready", s_w_ready, exp_awr);
      chk("ar_ready", s_ar_ready, exp_arr);
      chk("wb_cyc", wb_cyc_o, exp_cyc);
      chk("wb_stb", wb_stb_o, exp_cyc);
      if (exp_cyc != 0) begin
        chk("wb_adr", wb_adr_o, m_addr);
        chk("wb_we", wb_we_o, m_we);
        chk("wb_sel", wb_sel_o, m_strb);
        chk("wb_dat", wb_dat_o, m_wdat);
      end
      chk("b_valid", s_b_valid, exp_bv);
      chk("r_valid", s_r_valid, exp_rv);
      if (exp_bv) chk("b_resp", s_b_resp, m_resp);
      if (exp_rv) begin
        chk("r_resp", s_r_resp, m_resp);
        chk("r_data", s_r_data, m_rdat);
      end
      if ((exp_bv && s_b_ready) || (exp_rv && s_r_ready)) m_busy = 1'b0;
    end
  end

  // driver: one transaction with literal expectations for response, latency and channel
  task automatic run_txn(input string nm, input bit is_wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb, input int w_delay,
                         input int hold, input logic [1:0] exp_resp, input logic [DW-1:0] exp_data,
                         input int exp_lat, input logic [NS-1:0] exp_cyc);
    bit got;
    int lat;
    logic [NS-1:0] seen;
    @(posedge clk); #1;
    if (is_wr) begin
      s_aw_addr = addr; s_aw_valid = 1'b1; s_w_data = data; s_w_strb = strb;
      for (int i = 0; i < w_delay; i++) begin
        @(negedge clk);
        chk({nm, "_no_ready_without_w"}, {s_aw_ready, s_w_ready}, 0);
        @(posedge clk); #1;
      end
      s_w_valid = 1'b1;
    end else begin
      s_ar_addr = addr; s_ar_valid = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = is_wr ? (s_aw_ready && s_w_ready) : s_ar_ready;
    end
    chk({nm, "_accepted"}, got, 1);
    @(posedge clk); #1;
    s_aw_valid = 1'b0; s_w_valid = 1'b0; s_ar_valid = 1'b0;
    if (hold > 0) begin
      s_b_ready = 1'b0; s_r_ready = 1'b0;
    end
    lat = 1; seen = '0; got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      seen = seen | wb_cyc_o;
      got = is_wr ? s_b_valid : s_r_valid;
      if (!got) lat++;
    end
    chk({nm, "_resp_seen"}, got, 1);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_channel"}, seen, exp_cyc);
    chk({nm, "_resp"}, is_wr ? s_b_resp : s_r_resp, exp_resp);
    if (!is_wr) chk({nm, "_rdata"}, s_r_data, exp_data);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({nm, "_hold_valid"}, is_wr ? s_b_valid : s_r_valid, 1);
        if (!is_wr) chk({nm, "_hold_data"}, s_r_data, exp_data);
      end
      @(posedge clk); #1;
      s_b_ready = 1'b1; s_r_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic set_ch(input int ch, input int lat, input int mode, input logic [DW-1:0] dat);
    cfg_lat[ch] = lat; cfg_mode[ch] = mode; cfg_dat[ch] = dat;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [3:0] order;
    int n;
    bit got;
    for (int i = 0; i < NS; i++) set_ch(i, 0, 0, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_b_resp", s_b_resp, 0);
    chk("rst_r_data", s_r_data, 0);

    set_ch(1, 3, 0, 32'hAAAA_5555);
    run_txn("wr_ch1", 1, 32'h7000_1004, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00, 0, 5, 4'b0010);
    set_ch(2, 0, 0, 32'h1234_5678);
    run_txn("rd_ch2", 0, 32'h7000_2008, 0, 0, 0, 0, 2'b00, 32'h1234_5678, 2, 4'b0100);
    run_txn("rd_miss", 0, 32'h8000_0000, 0, 0, 0, 0, 2'b11, 32'h0, 1, 4'b0000);
    set_ch(0, 1, 0, 32'h0BAD_0000);
    run_txn("wr_ch0_aw_first", 1, 32'h7000_0020, 32'h0102_0304, 4'h3, 3, 0, 2'b00, 0, 3, 4'b0001);
    noise = 1'b1;
    set_ch(1, 2, 0, 32'hCAFE_F00D);
    run_txn("rd_ch1_noise", 0, 32'h7000_1FFC, 0, 0, 0, 0, 2'b00, 32'hCAFE_F00D, 4, 4'b0010);
    noise = 1'b0;
    set_ch(0, 0, 2, 32'h5A5A_5A5A);
    run_txn("rd_ack_err", 0, 32'h7000_0010, 0, 0, 0, 0, 2'b10, 32'h0, 2, 4'b0001);
    set_ch(2, 1, 1, 32'h0);
    run_txn("wr_err", 1, 32'h7000_2000, 32'h1111_2222, 4'hC, 0, 0, 2'b10, 0, 3, 4'b0100);
    set_ch(3, 0, 3, 32'h0);
    run_txn("wr_timeout", 1, 32'h7000_3000, 32'h3333_4444, 4'hF, 0, 0, 2'b10, 0, TMO + 1, 4'b1000);
    set_ch(2, 0, 0, 32'h7654_3210);
    run_txn("rd_hold", 0, 32'h7000_2100, 0, 0, 0, 10, 2'b00, 32'h7654_3210, 2, 4'b0100);
    run_txn("wr_miss", 1, 32'h7000_4000, 32'h9999_9999, 4'hF, 0, 0, 2'b11, 0, 1, 4'b0000);

    // reset while a silent slave holds the cycle open
    @(posedge clk); #1;
    s_aw_addr = 32'h7000_3008; s_w_data = 32'h0; s_w_strb = 4'hF; s_aw_valid = 1'b1; s_w_valid = 1'b1;
    @(posedge clk); #1;
    s_aw_valid = 1'b0; s_w_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cyc", wb_cyc_o, 0);
    chk("midrst_stb", wb_stb_o, 0);
    chk("midrst_bvalid", s_b_valid, 0);
    chk("midrst_rvalid", s_r_valid, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // contention: write and read held together for four transactions
    set_ch(0, 0, 0, 32'h0);
    set_ch(1, 0, 0, 32'h1111_2222);
    @(posedge clk); #1;
    s_aw_addr = 32'h7000_0000; s_w_data = 32'hABCD_0000; s_w_strb = 4'hF;
    s_ar_addr = 32'h7000_1000;
    s_aw_valid = 1'b1; s_w_valid = 1'b1; s_ar_valid = 1'b1;
    order = '0; n = 0; got = 1'b0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (s_aw_ready) begin order = {order[2:0], 1'b1}; n++; end
      else if (s_ar_ready) begin order = {order[2:0], 1'b0}; n++; end
    end
    @(posedge clk); #1;
    s_aw_valid = 1'b0; s_w_valid = 1'b0; s_ar_valid = 1'b0;
    chk("arb_count", n, 4);
    chk("arb_order", order, 4'b1010);
    repeat (6) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
